// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte parser feeding a first-word-fall-through key-event FIFO with live modifier flags.
// Events land in the FIFO on the edge that takes their last byte; defining SCANCODE_ASCII_EN adds an ASCII view of the head.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [7:0] RX_DATA,
    input  logic       DATA_VALID,
    input  logic       KEY_READ,
    input  logic       CLEAR_OVF,
    output logic       KEY_AVAIL,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_BREAK,
    output logic       SHIFT,
    output logic       CTRL,
    output logic       ALT,
    output logic       OVERFLOW
`ifdef SCANCODE_ASCII_EN
    ,
    output logic [7:0] ASCII
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SCANCODE_ASCII_EN
    localparam int EW = 11;
`else
    localparam int EW = 10;
`endif
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  pause_cnt, pause_cnt_nxt;
    logic        emit, emit_ext, emit_brk;
    logic [7:0]  emit_code;
    logic        fake_shift;

    // E0 12 / E0 59 are the keyboard's synthetic shift wrappers around nav keys.
    assign fake_shift = (RX_DATA == 8'h12) || (RX_DATA == 8'h59);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            pause_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            pause_cnt <= pause_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pause_cnt_nxt = pause_cnt;
        emit          = 1'b0;
        emit_ext      = 1'b0;
        emit_brk      = 1'b0;
        emit_code     = RX_DATA;
        if (DATA_VALID) begin
            if (RX_DATA == 8'h00 || RX_DATA == 8'hFF) begin
                state_nxt     = IDLE;
                pause_cnt_nxt = 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        case (RX_DATA)
                            8'hE0: state_nxt = EXT;
                            8'hF0: state_nxt = BRK;
                            8'hE1: begin
                                state_nxt     = PAUSE;
                                pause_cnt_nxt = 3'd0;
                            end
                            8'hAA, 8'hFA, 8'hEE, 8'hFE: state_nxt = IDLE;
                            default: emit = 1'b1;
                        endcase
                    end
                    EXT: begin
                        if (RX_DATA == 8'hF0) begin
                            state_nxt = EXTBRK;
                        end else begin
                            state_nxt = IDLE;
                            emit      = !fake_shift;
                            emit_ext  = 1'b1;
                        end
                    end
                    BRK: begin
                        state_nxt = IDLE;
                        emit      = 1'b1;
                        emit_brk  = 1'b1;
                    end
                    EXTBRK: begin
                        state_nxt = IDLE;
                        emit      = !fake_shift;
                        emit_ext  = 1'b1;
                        emit_brk  = 1'b1;
                    end
                    PAUSE: begin
                        if (pause_cnt == 3'd6) begin
                            state_nxt     = IDLE;
                            pause_cnt_nxt = 3'd0;
                            emit          = 1'b1;
                            emit_ext      = 1'b1;
                            emit_code     = 8'hE1;
                        end else begin
                            pause_cnt_nxt = pause_cnt + 3'd1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    logic lshift, rshift, lctrl, rctrl, lalt, ralt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            lctrl  <= 1'b0;
            rctrl  <= 1'b0;
            lalt   <= 1'b0;
            ralt   <= 1'b0;
        end else if (emit) begin
            case ({emit_ext, emit_code})
                {1'b0, 8'h12}: lshift <= !emit_brk;
                {1'b0, 8'h59}: rshift <= !emit_brk;
                {1'b0, 8'h14}: lctrl  <= !emit_brk;
                {1'b1, 8'h14}: rctrl  <= !emit_brk;
                {1'b0, 8'h11}: lalt   <= !emit_brk;
                {1'b1, 8'h11}: ralt   <= !emit_brk;
                default: ;
            endcase
        end
    end

    assign SHIFT = lshift | rshift;
    assign CTRL  = lctrl | rctrl;
    assign ALT   = lalt | ralt;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, push, drop;
    logic [EW-1:0] wr_entry, head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = KEY_READ && !empty;
    // A pop in the same cycle frees the slot the incoming event needs.
    assign push  = emit && (!full || pop);
    assign drop  = emit && full && !pop;

`ifdef SCANCODE_ASCII_EN
    assign wr_entry = {SHIFT, emit_ext, emit_brk, emit_code};
`else
    assign wr_entry = {emit_ext, emit_brk, emit_code};
`endif

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (drop)           OVERFLOW <= 1'b1;
            else if (CLEAR_OVF) OVERFLOW <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign KEY_AVAIL = !empty;
    assign KEY_CODE  = empty ? 8'h00 : head[7:0];
    assign KEY_BREAK = !empty && head[8];
    assign KEY_EXT   = !empty && head[9];

`ifdef SCANCODE_ASCII_EN
    logic [7:0] letter, other;

    always_comb begin
        letter = 8'h00;
        other  = 8'h00;
        case (head[7:0])
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            8'h16: other = 8'h31;   8'h1E: other = 8'h32;   8'h26: other = 8'h33;
            8'h25: other = 8'h34;   8'h2E: other = 8'h35;   8'h36: other = 8'h36;
            8'h3D: other = 8'h37;   8'h3E: other = 8'h38;   8'h46: other = 8'h39;
            8'h45: other = 8'h30;   8'h29: other = 8'h20;   8'h5A: other = 8'h0D;
            8'h66: other = 8'h08;
            default: ;
        endcase
        ASCII = 8'h00;
        if (!empty && !head[9] && !head[8]) begin
            if (letter != 8'h00) ASCII = head[10] ? (letter - 8'h20) : letter;
            else                 ASCII = other;
        end
    end
`endif

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, key-event FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port CLOCK, input, 1, single system clock; all logic on posedge.
REQ-003 SHALL have port RESET, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port RX_DATA, input, 8, received PS/2 byte from the upstream receiver.
REQ-005 SHALL have port DATA_VALID, input, 1, one-CLOCK pulse qualifying RX_DATA.
REQ-006 SHALL have port KEY_READ, input, 1, pops the FIFO head.
REQ-007 SHALL have port CLEAR_OVF, input, 1, clears OVERFLOW.
REQ-008 SHALL have port KEY_AVAIL, output, 1, FIFO non-empty.
REQ-009 SHALL have port KEY_CODE, output, 8, head event scan code.
REQ-010 SHALL have port KEY_EXT, output, 1, head event had E0 prefix.
REQ-011 SHALL have port KEY_BREAK, output, 1, head event is a release.
REQ-012 SHALL have ports SHIFT, CTRL, ALT, outputs, 1 each, live modifier-held flags.
REQ-013 SHALL have port OVERFLOW, output, 1, sticky event-drop flag.

Function
REQ-014 SHALL consume exactly one byte per CLOCK cycle in which DATA_VALID=1; other cycles leave the parser unchanged.
REQ-015 SHALL implement parser states IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0), PAUSE.
REQ-016 SHALL transition: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXTBRK; IDLE+E1->PAUSE; any other byte in IDLE/EXT/BRK/EXTBRK emits event {ext, brk, code} and returns to IDLE.
REQ-017 SHALL, in IDLE, discard bytes AA, FA, EE, FE with no event.
REQ-018 SHALL, on byte 00 or FF in any state, abort to IDLE with no event.
REQ-019 SHALL, in PAUSE, discard the next 7 bytes via a 3-bit counter, then emit one event {ext=1, brk=0, code=E1} and return to IDLE.
REQ-020 SHALL discard E0 12 and E0 59 sequences (make or break) entirely.
REQ-021 SHALL update modifiers on each decoded event regardless of FIFO state: 12/59 -> SHIFT (OR of left/right held), 14 and E0 14 -> CTRL, 11 and E0 11 -> ALT; set on make, clear on break of that key.
REQ-022 SHALL push an emitted event into the FIFO on the cycle after its final DATA_VALID; KEY_AVAIL rises that same following cycle.
REQ-023 SHALL present the FIFO head combinationally on KEY_CODE/KEY_EXT/KEY_BREAK (first-word-fall-through) whenever KEY_AVAIL=1; head outputs are 0 when empty.
REQ-024 SHALL pop on KEY_READ=1 with KEY_AVAIL=1; KEY_READ while empty is ignored.
REQ-025 SHALL, when full, drop an incoming event and set OVERFLOW, unless a pop occurs the same cycle, in which case both succeed and OVERFLOW is unchanged.
REQ-026 SHALL clear OVERFLOW on CLEAR_OVF=1; a simultaneous drop wins (OVERFLOW stays 1).
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH using an extra occupancy bit to distinguish full/empty.

Reset
REQ-028 SHALL, while RESET=0, force parser to IDLE, pause counter 0, FIFO empty, KEY_AVAIL/KEY_CODE/KEY_EXT/KEY_BREAK 0, SHIFT/CTRL/ALT 0, OVERFLOW 0.
REQ-029 SHALL discard any partial prefix sequence on reset mid-operation; no event is emitted from bytes before RESET rises.

Configuration
REQ-030 SHALL, with SCANCODE_ASCII_EN defined, add output ASCII [7:0] translating the head event: set-2 letters (1C=a ... 1A=z), top-row digits, 29->20, 5A->0D, 66->08; letters upper-case if SHIFT was held at push time (shift bit stored per entry).
REQ-031 SHALL output ASCII=00 for extended, break, unmapped, or empty-FIFO heads.
REQ-032 SHALL, without SCANCODE_ASCII_EN, omit the ASCII port and the per-entry shift bit.

Verification
REQ-033 SHALL cover: bytes 1C, F0 1C -> two events {0,0,1C} then {0,1,1C}; KEY_AVAIL high one cycle after first DATA_VALID.
REQ-034 SHALL cover: E0 F0 75 -> one event {ext=1, brk=1, 75}; E0 12 E0 75 -> only {1,0,75}.
REQ-035 SHALL cover: 5 makes with no KEY_READ, FIFO_DEPTH=4 -> 4 events kept, OVERFLOW=1; CLEAR_OVF -> 0; push+pop when full -> no overflow.
REQ-036 SHALL cover: E1 14 77 E1 F0 14 F0 77 -> single event {1,0,E1}; SHIFT/CTRL unchanged.
REQ-037 SHALL cover: 12 then 1C with SCANCODE_ASCII_EN -> ASCII=41 for the 1C entry; F0 12 then 1C -> ASCII=61; RESET low after lone E0 then 1C -> {0,0,1C}.
